// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory (combinational read, write on posedge)
//   between the CPU load/store path (master 0) and the loader/debug port
//   (master 1). Master 0 has fixed priority. Master 1 wins after STARVE_LIM
//   consecutive denied cycles, and can hold the memory for a locked burst of
//   up to MAX_BURST grants. One access is granted per cycle. Read data and the
//   error flags come back registered, one cycle after the grant.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata        master X request, write flag, byte address, write data
//   m1_lock                     master 1 asks for a locked burst
//   mX_gnt                      combinational grant; the access completes this cycle
//   mX_rvalid/rdata             read return, one cycle after a granted in-range read
//   mX_err                      pulse one cycle after a granted out-of-range access
//   mem_a/wd/we, mem_rd         datamem interface
module dmem_arbiter #(
    parameter int IDX_W      = 5,
    parameter int STARVE_LIM = 4,
    parameter int MAX_BURST  = 8   // assumed >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam int WC_W = $clog2(STARVE_LIM + 1);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [WC_W-1:0] WC_LIM  = WC_W'(STARVE_LIM);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, LOCK1} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic [BC_W-1:0] burst_cnt;
    logic            burst_end_p1;   // previous cycle closed a full-length burst

    logic            gnt0_p0, gnt1_p0;
    logic [31:0]     sel_addr, sel_wd;
    logic            sel_we, sel_ok;
    logic            vld0_p1, vld1_p1, err0_p1, err1_p1;
    logic [31:0]     rdata0_p1, rdata1_p1;

    function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] v);
        return (v == WC_LIM) ? v : v + WC_W'(1);
    endfunction

    function automatic logic addr_in_range(input logic [31:0] a);
        return a[31:IDX_W+2] == '0;
    endfunction

    // Stage p0: arbitration and memory mux (combinational)
    always_comb begin
        gnt0_p0 = 1'b0;
        gnt1_p0 = 1'b0;
        if (rst_n) begin
            if (state == LOCK1) begin
                // A running burst owns the memory; master 0 is held off.
                gnt1_p0 = m1_req & m1_lock;
            end else if (m1_req && wait_cnt == WC_LIM && !(burst_end_p1 && m0_req)) begin
                gnt1_p0 = 1'b1;
            end else if (m0_req) begin
                gnt0_p0 = 1'b1;
            end else if (m1_req) begin
                gnt1_p0 = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_wd   = '0;
        sel_we   = 1'b0;
        if (gnt0_p0) begin
            sel_addr = m0_addr;
            sel_wd   = m0_wdata;
            sel_we   = m0_we;
        end else if (gnt1_p0) begin
            sel_addr = m1_addr;
            sel_wd   = m1_wdata;
            sel_we   = m1_we;
        end
    end

    assign sel_ok = addr_in_range(sel_addr);
    assign mem_a  = sel_addr;
    assign mem_wd = sel_wd;
    assign mem_we = sel_we & sel_ok;
    assign m0_gnt = gnt0_p0;
    assign m1_gnt = gnt1_p0;

    // Stage p1: read return, error flags, arbitration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            burst_cnt    <= '0;
            burst_end_p1 <= 1'b0;
            vld0_p1      <= 1'b0;
            vld1_p1      <= 1'b0;
            err0_p1      <= 1'b0;
            err1_p1      <= 1'b0;
            rdata0_p1    <= '0;
            rdata1_p1    <= '0;
        end else begin
            vld0_p1 <= gnt0_p0 & ~m0_we & sel_ok;
            vld1_p1 <= gnt1_p0 & ~m1_we & sel_ok;
            err0_p1 <= gnt0_p0 & ~sel_ok;
            err1_p1 <= gnt1_p0 & ~sel_ok;
            if (gnt0_p0 && !m0_we && sel_ok) rdata0_p1 <= mem_rd;
            if (gnt1_p0 && !m1_we && sel_ok) rdata1_p1 <= mem_rd;

            wait_cnt     <= (!m1_req || gnt1_p0) ? '0 : sat_inc(wait_cnt);
            burst_end_p1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (gnt1_p0 && m1_lock) begin
                        state     <= LOCK1;
                        burst_cnt <= BC_W'(1);
                    end
                end
                LOCK1: begin
                    if (!gnt1_p0) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (burst_cnt == BC_LAST) begin
                        // This grant is the MAX_BURST-th: close the burst and
                        // give master 0 the next cycle.
                        state        <= IDLE;
                        burst_cnt    <= '0;
                        burst_end_p1 <= 1'b1;
                    end else begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_rvalid = vld0_p1;
    assign m1_rvalid = vld1_p1;
    assign m0_err    = err0_p1;
    assign m1_err    = err1_p1;
    assign m0_rdata  = rdata0_p1;
    assign m1_rdata  = rdata1_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a 32-word behavioural datamem.
//   Word i of the memory starts as 0xA5000000 | i.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] DEAD = 32'hDEADBEEF;

    always #5 clk = ~clk;

    dmem_arbiter #(.IDX_W(5), .STARVE_LIM(4), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    function automatic logic [31:0] init_w(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Behavioural datamem, filled on the first clock edge (inside reset).
    logic [31:0] mem [32];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_w(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_a[6:2]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a[6:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic lock);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd; m1_lock = lock;
    endtask

    initial begin
        // Reset: requests present, but nothing may be granted or written
        rst_n = 1'b0;
        set_m0(1'b1, 1'b1, 32'h0, 32'h1234);
        set_m1(1'b1, 1'b1, 32'h4, 32'h5678, 1'b0);
        #2;
        chk("rst gnt0", m0_gnt, 0);
        chk("rst gnt1", m1_gnt, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst rvalid0", m0_rvalid, 0);
        chk("rst err1", m1_err, 0);
        chk("rst rdata0", m0_rdata, 0);
        repeat (2) @(negedge clk);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: both requesting, no lock: m1 wins every 5th cycle
        set_m0(1'b1, 1'b0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("t1 gnt0 c%0d", i), m0_gnt, (i != 5 && i != 10));
            chk($sformatf("t1 gnt1 c%0d", i), m1_gnt, (i == 5 || i == 10));
            @(negedge clk);
        end
        chk("t1 rvalid1", m1_rvalid, 1);
        chk("t1 rdata1", m1_rdata, init_w(1));
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // 2: m1 writes 0x14, then m0 reads it back
        set_m1(1'b1, 1'b1, 32'h14, DEAD, 1'b0);
        #1;
        chk("t2 gnt1", m1_gnt, 1);
        chk("t2 gnt0", m0_gnt, 0);
        chk("t2 mem_we", mem_we, 1);
        chk("t2 mem_a", mem_a, 32'h14);
        chk("t2 mem_wd", mem_wd, DEAD);
        @(negedge clk);
        chk("t2 wr rvalid1", m1_rvalid, 0);
        chk("t2 wr err1", m1_err, 0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_m0(1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        chk("t2 rd gnt0", m0_gnt, 1);
        chk("t2 rd mem_we", mem_we, 0);
        chk("t2 rd mem_a", mem_a, 32'h14);
        @(negedge clk);
        chk("t2 rvalid0", m0_rvalid, 1);
        chk("t2 rdata0", m0_rdata, DEAD);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);

        // 3: locked burst against a continuously requesting m0
        set_m0(1'b1, 1'b0, 32'h8, 32'h0);
        set_m1(1'b1, 1'b0, 32'hC, 32'h0, 1'b1);
        for (int i = 1; i <= 13; i++) begin
            #1;
            chk($sformatf("t3 gnt1 c%0d", i), m1_gnt, (i >= 5 && i <= 12));
            chk($sformatf("t3 gnt0 c%0d", i), m0_gnt, (i < 5 || i == 13));
            @(negedge clk);
        end
        chk("t3 rdata1", m1_rdata, init_w(3));
        chk("t3 rvalid0", m0_rvalid, 1);
        chk("t3 rdata0", m0_rdata, init_w(2));
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);

        // 4: out-of-range accesses
        set_m0(1'b1, 1'b1, 32'h80, 32'hFFFF_FFFF);
        #1;
        chk("t4 gnt0", m0_gnt, 1);
        chk("t4 mem_we", mem_we, 0);
        chk("t4 mem_a", mem_a, 32'h80);
        @(negedge clk);
        chk("t4 err0", m0_err, 1);
        chk("t4 err rvalid0", m0_rvalid, 0);
        chk("t4 err rdata0", m0_rdata, init_w(2));
        set_m0(1'b1, 1'b0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        #1;
        chk("t4 rd gnt0", m0_gnt, 1);
        @(negedge clk);
        chk("t4 err0 cleared", m0_err, 0);
        chk("t4 word0 rvalid", m0_rvalid, 1);
        chk("t4 word0 intact", m0_rdata, init_w(0));
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t4 gnt1", m1_gnt, 1);
        @(negedge clk);
        chk("t4 err1", m1_err, 1);
        chk("t4 err rvalid1", m1_rvalid, 0);
        chk("t4 err rdata1", m1_rdata, init_w(3));
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t4 err1 pulse", m1_err, 0);

        // 6: back-to-back reads
        set_m0(1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6 rvalid a0", m0_rvalid, 1);
        chk("t6 rdata a0", m0_rdata, init_w(0));
        m0_addr = 32'h4;
        @(negedge clk);
        chk("t6 rvalid a4", m0_rvalid, 1);
        chk("t6 rdata a4", m0_rdata, init_w(1));
        m0_addr = 32'h8;
        @(negedge clk);
        chk("t6 rvalid a8", m0_rvalid, 1);
        chk("t6 rdata a8", m0_rdata, init_w(2));
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6 rvalid idle", m0_rvalid, 0);

        // 5: reset in the third cycle of an m1 burst
        set_m1(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        #1;
        chk("t5 gnt1 c1", m1_gnt, 1);
        @(negedge clk);
        #1;
        chk("t5 gnt1 c2", m1_gnt, 1);
        @(negedge clk);
        chk("t5 pre rvalid1", m1_rvalid, 1);
        chk("t5 pre rdata1", m1_rdata, init_w(4));
        m0_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("t5 rst gnt1", m1_gnt, 0);
        chk("t5 rst gnt0", m0_gnt, 0);
        chk("t5 rst rvalid1", m1_rvalid, 0);
        chk("t5 rst rdata1", m1_rdata, 0);
        chk("t5 rst err1", m1_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_m0(1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        chk("t5 post gnt0", m0_gnt, 1);
        chk("t5 post gnt1", m1_gnt, 0);
        @(negedge clk);
        chk("t5 mem kept rvalid", m0_rvalid, 1);
        chk("t5 mem kept rdata", m0_rdata, DEAD);
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
